// File: rtl/physics_pkg.sv
// rtl/physics_pkg.sv - shared widths, constants, FSM states and helpers for contact_pre_step
//
// Purpose: Q20 fixed-point widths, saturation limits, default tuning values,
//          the contact_pre_step state enum and two arithmetic helpers.
// Ports:   none (package).
package physics_pkg;

   localparam int Q_FRAC   = 20;
   localparam int W_NORM   = 22;
   localparam int W_MASS   = 29;
   localparam int W_POS    = 31;
   localparam int W_OP     = 35;
   localparam int W_PROD   = 2 * W_OP;
   localparam int W_KSUM   = 38;
   localparam int DIV_BITS = 41;

   localparam logic [W_MASS-1:0] MASS_SAT = 29'h0FFF_FFFF;   // 2^28-1
   localparam logic [W_POS-1:0]  BIAS_SAT = 31'h3FFF_FFFF;   // 2^30-1

   localparam int DEF_ALLOWED_PEN = 10486;      // ~0.01
   localparam int DEF_K_BIAS      = 12582912;   // 0.2 * 60 = 12.0

   typedef enum logic [3:0] {
      S_IDLE, S_CAPTURE, S_RT, S_RN, S_SQ, S_KSUM,
      S_DIV_N, S_DIV_T, S_BIAS, S_DONE
   } state_t;

   // Q20 product: full signed product, keep bits [54:20] (truncating).
   function automatic logic signed [W_OP-1:0] q20_mul(input logic signed [W_OP-1:0] a,
                                                      input logic signed [W_OP-1:0] b);
      return W_OP'((W_PROD'(a) * W_PROD'(b)) >>> Q_FRAC);
   endfunction

   // Clamp an effective-mass denominator into 35-bit unsigned range.
   function automatic logic [W_OP-1:0] k_clamp(input logic signed [W_KSUM-1:0] v);
      if (v[W_KSUM-1])
         return '0;
      else if (|v[W_KSUM-2:W_OP])
         return '1;
      else
         return v[W_OP-1:0];
   endfunction

endpackage

// File: rtl/contact_pre_step_if.sv
// rtl/contact_pre_step_if.sv - request/result bundle of the contact pre-solve stage
//
// Purpose: groups the start handshake, contact/body inputs and the result outputs.
// Modports: master (requester: drives start and geometry, reads results)
//           slave  (contact_pre_step: reads request, drives results, busy, done)
interface contact_pre_step_if;
   import physics_pkg::*;

   logic              start;
   logic [W_POS-1:0]  cPos_x, cPos_y;
   logic [W_NORM-1:0] cNorm_x, cNorm_y;
   logic [W_POS-1:0]  cSep;
   logic [W_POS-1:0]  b1Pos_x, b1Pos_y, b2Pos_x, b2Pos_y;
   logic [W_NORM-1:0] b1Inv_mass, b2Inv_mass, b1Inv_I, b2Inv_I;
   logic [W_MASS-1:0] cMassNorm, cMassTang;
   logic [W_POS-1:0]  cBias;
   logic              busy;
   logic              done;

   modport master (
      output start, cPos_x, cPos_y, cNorm_x, cNorm_y, cSep,
             b1Pos_x, b1Pos_y, b2Pos_x, b2Pos_y,
             b1Inv_mass, b2Inv_mass, b1Inv_I, b2Inv_I,
      input  cMassNorm, cMassTang, cBias, busy, done
   );

   modport slave (
      input  start, cPos_x, cPos_y, cNorm_x, cNorm_y, cSep,
             b1Pos_x, b1Pos_y, b2Pos_x, b2Pos_y,
             b1Inv_mass, b2Inv_mass, b1Inv_I, b2Inv_I,
      output cMassNorm, cMassTang, cBias, busy, done
   );

endinterface

// File: rtl/q20_recip.sv
// rtl/q20_recip.sv - sequential restoring divider computing 2^40 / k
//
// Purpose: one quotient bit per cycle, 41 cycles per division; quotient
//          saturated to 2^28-1 (k = 0 naturally yields all ones -> saturated).
// Ports:   clk, rst (async, active-high); start (accepted when not busy);
//          k (35-bit unsigned divisor); busy; done (one-cycle pulse);
//          q (saturated quotient, valid while done is high and until next start).
module q20_recip
   import physics_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [W_OP-1:0]   k,
   output logic              busy,
   output logic              done,
   output logic [W_MASS-1:0] q
);

   logic [W_OP-1:0]     k_q, rem, rem_src, k_src;
   logic [W_OP:0]       trial;
   logic [DIV_BITS-1:0] quo;
   logic [5:0]          cnt;
   logic                first, ge;

   // The accepting edge already processes quotient bit 40, so a division
   // occupies exactly 41 edges including the start edge.
   always_comb begin
      first   = start && !busy;
      rem_src = first ? '0 : rem;
      k_src   = first ? k : k_q;
      // Dividend is 2^40: only its leading bit (consumed on the first edge) is set.
      trial   = {rem_src, first};
      ge      = trial >= {1'b0, k_src};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q  <= '0;
         rem  <= '0;
         quo  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (first) begin
            k_q  <= k;
            rem  <= W_OP'(ge ? trial - {1'b0, k_src} : trial);
            quo  <= {{(DIV_BITS-1){1'b0}}, ge};
            cnt  <= 6'(DIV_BITS - 1);
            busy <= 1'b1;
         end else if (busy) begin
            rem <= W_OP'(ge ? trial - {1'b0, k_src} : trial);
            quo <= {quo[DIV_BITS-2:0], ge};
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign q = (quo > DIV_BITS'(MASS_SAT)) ? MASS_SAT : quo[W_MASS-1:0];

endmodule

// File: rtl/contact_pre_step.sv
// rtl/contact_pre_step.sv - per-contact pre-solve: effective masses and bias
//
// Purpose: captures one contact on start, computes cMassNorm/cMassTang (Q20,
//          2^40/k saturated) and cBias using four time-shared 35x35 multipliers
//          and one q20_recip divider; results are presented with a done pulse.
// Build option: CONTACT_PRESTEP_BIAS_EN enables the BIAS state and cBias;
//               otherwise cBias is 0 and cSep is unused.
// Ports: clk, rst (async, active-high); bus (contact_pre_step_if.slave):
//        start/geometry/inertia in, cMassNorm/cMassTang/cBias/busy/done out.
module contact_pre_step
   import physics_pkg::*;
#(
   parameter int ALLOWED_PEN = DEF_ALLOWED_PEN,
   parameter int K_BIAS      = DEF_K_BIAS
) (
   input logic               clk,
   input logic               rst,
   contact_pre_step_if.slave bus
);

   state_t state, state_nx;

   // Captured request, stored sign-extended to operand width.
   logic signed [W_OP-1:0] cpx, cpy, b1x, b1y, b2x, b2y;
   logic signed [W_OP-1:0] nx, ny, m1, m2, i1, i2;
   logic signed [W_OP-1:0] r1x, r1y, r2x, r2y;
   logic signed [W_OP-1:0] rt1, rt2, rn1, rn2;
   logic signed [W_OP-1:0] sq_rt1, sq_rt2, sq_rn1, sq_rn2;
   logic [W_OP-1:0]        k_t, k_n_comb, k_t_comb, div_k;
   logic [W_MASS-1:0]      mass_n, mass_t, mass_n_out, mass_t_out, div_q;
   logic [W_POS-1:0]       bias_out;
   logic                   done_q, div_start, div_busy, div_done;

   logic signed [W_OP-1:0] ma [4];
   logic signed [W_OP-1:0] mb [4];
   logic signed [W_OP-1:0] pt [4];

`ifdef CONTACT_PRESTEP_BIAS_EN
   logic signed [W_OP-1:0] sep, s_val;
   logic signed [31:0]     neg_b;
   logic [W_POS-1:0]       bias_val, bias_comb;
`else
   logic [W_POS-1:0] unused_sep;
   localparam int unused_params = ALLOWED_PEN + K_BIAS;
   assign unused_sep = bus.cSep;
`endif

   // Multiplier operand routing: each state reuses the same four multipliers.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ma[i] = '0;
         mb[i] = '0;
      end
      case (state)
         S_RT: begin
            ma[0] = r1x; mb[0] = ny;
            ma[1] = r1y; mb[1] = nx;
            ma[2] = r2x; mb[2] = ny;
            ma[3] = r2y; mb[3] = nx;
         end
         S_RN: begin
            ma[0] = r1x; mb[0] = nx;
            ma[1] = r1y; mb[1] = ny;
            ma[2] = r2x; mb[2] = nx;
            ma[3] = r2y; mb[3] = ny;
         end
         S_SQ: begin
            ma[0] = rt1; mb[0] = rt1;
            ma[1] = rt2; mb[1] = rt2;
            ma[2] = rn1; mb[2] = rn1;
            ma[3] = rn2; mb[3] = rn2;
         end
         S_KSUM: begin
            ma[0] = i1; mb[0] = sq_rt1;
            ma[1] = i2; mb[1] = sq_rt2;
            ma[2] = i1; mb[2] = sq_rn1;
            ma[3] = i2; mb[3] = sq_rn2;
         end
`ifdef CONTACT_PRESTEP_BIAS_EN
         S_BIAS: begin
            ma[0] = s_val; mb[0] = W_OP'(K_BIAS);
         end
`endif
         default: ;
      endcase
      for (int i = 0; i < 4; i++)
         pt[i] = q20_mul(ma[i], mb[i]);
   end

   always_comb begin
      k_n_comb = k_clamp(W_KSUM'(m1) + W_KSUM'(m2) + W_KSUM'(pt[0]) + W_KSUM'(pt[1]));
      k_t_comb = k_clamp(W_KSUM'(m1) + W_KSUM'(m2) + W_KSUM'(pt[2]) + W_KSUM'(pt[3]));
   end

`ifdef CONTACT_PRESTEP_BIAS_EN
   // Only penetration beyond the slop produces a bias; the Q20 product keeps
   // bits [50:20] before negation.
   always_comb begin
      s_val     = sep + W_OP'(ALLOWED_PEN);
      neg_b     = -(32'($signed(pt[0][30:0])));
      bias_comb = '0;
      if (s_val[W_OP-1] && !neg_b[31]) begin
         if (neg_b > 32'sd1073741823)
            bias_comb = BIAS_SAT;
         else
            bias_comb = neg_b[W_POS-1:0];
      end
   end
`endif

   // kN goes straight into the divider from KSUM; kT waits in a register
   // and is launched the cycle the kN division completes.
   assign div_start = (state == S_KSUM) || (state == S_DIV_N && div_done);
   assign div_k     = (state == S_KSUM) ? k_n_comb : k_t;

   q20_recip u_recip (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .k     (div_k),
      .busy  (div_busy),
      .done  (div_done),
      .q     (div_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (bus.start) state_nx = S_CAPTURE;
         S_CAPTURE: state_nx = S_RT;
         S_RT:      state_nx = S_RN;
         S_RN:      state_nx = S_SQ;
         S_SQ:      state_nx = S_KSUM;
         S_KSUM:    state_nx = S_DIV_N;
         S_DIV_N:   if (div_done) state_nx = S_DIV_T;
`ifdef CONTACT_PRESTEP_BIAS_EN
         S_DIV_T:   if (div_done) state_nx = S_BIAS;
         S_BIAS:    state_nx = S_DONE;
`else
         S_DIV_T:   if (div_done) state_nx = S_DONE;
`endif
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {cpx, cpy, b1x, b1y, b2x, b2y} <= '0;
         {nx, ny, m1, m2, i1, i2}       <= '0;
         {r1x, r1y, r2x, r2y}           <= '0;
         {rt1, rt2, rn1, rn2}           <= '0;
         {sq_rt1, sq_rt2, sq_rn1, sq_rn2} <= '0;
         k_t        <= '0;
         mass_n     <= '0;
         mass_t     <= '0;
         mass_n_out <= '0;
         mass_t_out <= '0;
         bias_out   <= '0;
         done_q     <= 1'b0;
`ifdef CONTACT_PRESTEP_BIAS_EN
         sep      <= '0;
         bias_val <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: if (bus.start) begin
               cpx <= W_OP'($signed(bus.cPos_x));
               cpy <= W_OP'($signed(bus.cPos_y));
               b1x <= W_OP'($signed(bus.b1Pos_x));
               b1y <= W_OP'($signed(bus.b1Pos_y));
               b2x <= W_OP'($signed(bus.b2Pos_x));
               b2y <= W_OP'($signed(bus.b2Pos_y));
               nx  <= W_OP'($signed(bus.cNorm_x));
               ny  <= W_OP'($signed(bus.cNorm_y));
               m1  <= W_OP'($signed(bus.b1Inv_mass));
               m2  <= W_OP'($signed(bus.b2Inv_mass));
               i1  <= W_OP'($signed(bus.b1Inv_I));
               i2  <= W_OP'($signed(bus.b2Inv_I));
`ifdef CONTACT_PRESTEP_BIAS_EN
               sep <= W_OP'($signed(bus.cSep));
`endif
            end
            S_CAPTURE: begin
               r1x <= cpx - b1x;
               r1y <= cpy - b1y;
               r2x <= cpx - b2x;
               r2y <= cpy - b2y;
            end
            S_RT: begin
               rt1 <= pt[0] - pt[1];
               rt2 <= pt[2] - pt[3];
            end
            S_RN: begin
               rn1 <= pt[0] + pt[1];
               rn2 <= pt[2] + pt[3];
            end
            S_SQ: begin
               sq_rt1 <= pt[0];
               sq_rt2 <= pt[1];
               sq_rn1 <= pt[2];
               sq_rn2 <= pt[3];
            end
            S_KSUM:  k_t <= k_t_comb;
            S_DIV_N: if (div_done) mass_n <= div_q;
            S_DIV_T: if (div_done) mass_t <= div_q;
`ifdef CONTACT_PRESTEP_BIAS_EN
            S_BIAS:  bias_val <= bias_comb;
`endif
            S_DONE: begin
               mass_n_out <= mass_n;
               mass_t_out <= mass_t;
`ifdef CONTACT_PRESTEP_BIAS_EN
               bias_out   <= bias_val;
`endif
               done_q     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.cMassNorm = mass_n_out;
   assign bus.cMassTang = mass_t_out;
   assign bus.cBias     = bias_out;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = done_q;

endmodule
